// File: rtl/program_rom_server_if.sv
`default_nettype none
// ============================================================================
// Module      : program_rom_server_if
// Description : Bundles the program load stream and the fetch port of the
//               program store. This interface carries the following signals:
//                 load_start / load_base / load_count : open a load session
//                 load_valid / load_data / load_ready : byte stream handshake
//                 load_done / load_sum / run_enable   : load status
//                 fetch_addr / fetch_data             : counter fetch port
//               The master modport is the host/counter side. The slave
//               modport is the store side.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_rom_server_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W-1:0] load_count;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic [DATA_W-1:0] load_sum;
    logic              run_enable;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;

    modport slave (
        input  load_start, load_base, load_count, load_valid, load_data,
               fetch_addr,
        output load_ready, load_done, load_sum, run_enable, fetch_data
    );

    modport master (
        output load_start, load_base, load_count, load_valid, load_data,
               fetch_addr,
        input  load_ready, load_done, load_sum, run_enable, fetch_data
    );
endinterface
`default_nettype wire

// File: rtl/program_rom_server.sv
`default_nettype none
// ============================================================================
// Module      : program_rom_server
// Description : 2^ADDR_W x DATA_W program store. A host loads the store over
//               a valid/ready byte stream, and the program counter fetches
//               from it with one cycle of read latency.
//               Ports:
//                 clk   : system clock, rising edge
//                 rst_n : asynchronous active-low reset
//                 bus   : load stream, load status and fetch port (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module program_rom_server #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    program_rom_server_if.slave        bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;

    // remaining is one bit wider than an address, so a count of 0 can hold
    // the full depth.
    localparam logic [ADDR_W:0]   c_REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_REM_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] c_PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   remaining_q;
    logic [DATA_W-1:0] sum_q;
    logic              done_q;
    logic              run_q;
    logic [DATA_W-1:0] fetch_q;
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic              w_xfer;
    logic              w_last;

    assign w_xfer = (state_q == S_LOAD) && bus.load_valid;
    assign w_last = w_xfer && (remaining_q == c_REM_ONE);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A restart takes priority over completion of the current session.
    always_comb begin
        state_d = state_q;
        if (bus.load_start) begin
            state_d = S_LOAD;
        end else if (w_last) begin
            state_d = S_READY;
        end
    end

    always_comb begin
        bus.load_ready = (state_q == S_LOAD);
        bus.load_done  = done_q;
        bus.load_sum   = sum_q;
        bus.run_enable = run_q;
        bus.fetch_data = fetch_q;
    end

    // ---------------------------------------------------------- session data
    // A byte accepted in the same cycle as load_start is still written to
    // memory, at the old pointer. The restart then discards it from the
    // count and from the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            remaining_q <= '0;
            sum_q       <= '0;
            done_q      <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load_start) begin
                ptr_q       <= bus.load_base;
                remaining_q <= (bus.load_count == '0) ? c_REM_FULL
                                                      : {1'b0, bus.load_count};
                sum_q       <= '0;
                run_q       <= 1'b0;
            end else if (w_xfer) begin
                ptr_q       <= ptr_q + c_PTR_ONE;
                remaining_q <= remaining_q - c_REM_ONE;
                sum_q       <= sum_q + bus.load_data;
                if (w_last) begin
                    done_q <= 1'b1;
                    run_q  <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- memory
    // The storage array has no reset, so a program survives a reset.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            mem_q[ptr_q] <= bus.load_data;
        end
    end

    // Outside READY the counter sees zeros, which decode as a harmless NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_q <= '0;
        end else if (state_q == S_READY) begin
            fetch_q <= mem_q[bus.fetch_addr];
        end else begin
            fetch_q <= '0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_program_rom_server.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_rom_server
// Description : Self-checking bench for program_rom_server. The bench applies
//               a table of directed vectors. Each vector holds one cycle of
//               stimulus and the outputs that must appear after that edge.
//               Hand-written sequences cover a full-depth load and a reset
//               in the middle of a load.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_rom_server;
    typedef struct {
        logic       start;
        logic [7:0] base;
        logic [7:0] count;
        logic       valid;
        logic [7:0] data;
        logic [7:0] faddr;
        logic       e_ready;
        logic       e_done;
        logic [7:0] e_sum;
        logic       e_run;
        logic [7:0] e_fetch;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    vec_t vecs[$];

    program_rom_server_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    program_rom_server #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [7:0] base,
                       input logic [7:0] cnt, input logic v,
                       input logic [7:0] d, input logic [7:0] fa,
                       input logic er, input logic ed, input logic [7:0] es,
                       input logic erun, input logic [7:0] ef);
        vec_t r;
        r.start = st;  r.base = base; r.count = cnt; r.valid = v;
        r.data = d;    r.faddr = fa;  r.e_ready = er; r.e_done = ed;
        r.e_sum = es;  r.e_run = erun; r.e_fetch = ef;
        vecs.push_back(r);
    endtask

    task automatic drive(input logic st, input logic [7:0] base,
                         input logic [7:0] cnt, input logic v,
                         input logic [7:0] d, input logic [7:0] fa);
        bus.load_start = st;
        bus.load_base  = base;
        bus.load_count = cnt;
        bus.load_valid = v;
        bus.load_data  = d;
        bus.fetch_addr = fa;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input int idx, input logic er,
                           input logic ed, input logic [7:0] es,
                           input logic erun, input logic [7:0] ef);
        chk({nm, ".ready"}, idx, 32'(bus.load_ready), 32'(er));
        chk({nm, ".done"},  idx, 32'(bus.load_done),  32'(ed));
        chk({nm, ".sum"},   idx, 32'(bus.load_sum),   32'(es));
        chk({nm, ".run"},   idx, 32'(bus.run_enable), 32'(erun));
        chk({nm, ".fetch"}, idx, 32'(bus.fetch_data), 32'(ef));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        //   st base  cnt  v  data  faddr  rdy dn sum  run fetch
        // basic load of 4 bytes at 0x00, then fetch
        add(1, 8'h00, 8'd4, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h11, 8'h00, 1, 0, 8'h11, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h22, 8'h00, 1, 0, 8'h33, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h33, 8'h00, 1, 0, 8'h66, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h44, 8'h00, 0, 1, 8'hAA, 1, 8'h00);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h00, 0, 0, 8'hAA, 1, 8'h11);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h01, 0, 0, 8'hAA, 1, 8'h22);
        add(0, 8'h00, 8'd0, 1, 8'h99, 8'h02, 0, 0, 8'hAA, 1, 8'h33);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h03, 0, 0, 8'hAA, 1, 8'h44);
        // wrap: base 0xFE, count 3
        add(1, 8'hFE, 8'd3, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h11);
        add(0, 8'h00, 8'd0, 1, 8'h01, 8'h00, 1, 0, 8'h01, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h02, 8'h00, 1, 0, 8'h03, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h03, 8'h00, 0, 1, 8'h06, 1, 8'h00);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'hFE, 0, 0, 8'h06, 1, 8'h01);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'hFF, 0, 0, 8'h06, 1, 8'h02);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h00, 0, 0, 8'h06, 1, 8'h03);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h01, 0, 0, 8'h06, 1, 8'h22);
        // stalled source: valid 1,0,0,1,1 for a count-3 load at 0x20
        add(1, 8'h20, 8'd3, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h03);
        add(0, 8'h00, 8'd0, 1, 8'hA0, 8'h20, 1, 0, 8'hA0, 0, 8'h00);
        add(0, 8'h00, 8'd0, 0, 8'hFF, 8'h20, 1, 0, 8'hA0, 0, 8'h00);
        add(0, 8'h00, 8'd0, 0, 8'hFF, 8'h20, 1, 0, 8'hA0, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'hB0, 8'h20, 1, 0, 8'h50, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'hC0, 8'h20, 0, 1, 8'h10, 1, 8'h00);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h20, 0, 0, 8'h10, 1, 8'hA0);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h21, 0, 0, 8'h10, 1, 8'hB0);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h22, 0, 0, 8'h10, 1, 8'hC0);
        // reload from READY at 0x10, restart mid-session to 0x30
        add(1, 8'h10, 8'd2, 0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h03);
        add(0, 8'h00, 8'd0, 1, 8'h05, 8'h00, 1, 0, 8'h05, 0, 8'h00);
        add(1, 8'h30, 8'd2, 1, 8'h06, 8'h00, 1, 0, 8'h00, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h07, 8'h00, 1, 0, 8'h07, 0, 8'h00);
        add(0, 8'h00, 8'd0, 1, 8'h08, 8'h00, 0, 1, 8'h0F, 1, 8'h00);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h10, 0, 0, 8'h0F, 1, 8'h05);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h11, 0, 0, 8'h0F, 1, 8'h06);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h30, 0, 0, 8'h0F, 1, 8'h07);
        add(0, 8'h00, 8'd0, 0, 8'h00, 8'h31, 0, 0, 8'h0F, 1, 8'h08);

        // reset and idle
        rst_n = 1'b0;
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 8'h00, 0, 8'h00);
        rst_n = 1'b1;
        step();
        chk_all("idle", 0, 0, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].base, vecs[i].count,
                  vecs[i].valid, vecs[i].data, vecs[i].faddr);
            step();
            chk_all("vec", i, vecs[i].e_ready, vecs[i].e_done,
                    vecs[i].e_sum, vecs[i].e_run, vecs[i].e_fetch);
        end

        // full depth: count 0 takes exactly 256 bytes, values 0..255 at 0x40
        drive(1, 8'h40, 8'h00, 0, 8'h00, 8'h00);
        step();
        chk("full.ready0", 0, 32'(bus.load_ready), 32'd1);
        for (int i = 0; i < 256; i++) begin
            drive(0, 8'h00, 8'h00, 1, 8'(i), 8'h00);
            step();
            if (i < 255) begin
                chk("full.done_early", i, 32'(bus.load_done), 32'd0);
                chk("full.ready", i, 32'(bus.load_ready), 32'd1);
            end
        end
        // sum of 0..255 = 32640 = 0x7F80, low byte 0x80
        chk_all("full.end", 0, 0, 1, 8'h80, 1, 8'h00);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h40);
        step();
        chk("full.mem40", 0, 32'(bus.fetch_data), 32'h00);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h3F);
        step();
        chk("full.mem3F", 0, 32'(bus.fetch_data), 32'hFF);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'hA0);
        step();
        chk("full.memA0", 0, 32'(bus.fetch_data), 32'h60);

        // reset after 2 of 5 bytes at 0x50
        drive(1, 8'h50, 8'd5, 0, 8'h00, 8'h50);
        step();
        drive(0, 8'h00, 8'h00, 1, 8'hAB, 8'h50);
        step();
        drive(0, 8'h00, 8'h00, 1, 8'hCD, 8'h50);
        step();
        chk("mid.sum2", 0, 32'(bus.load_sum), 32'h78);
        drive(0, 8'h00, 8'h00, 1, 8'hEF, 8'h50);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("mid.rst", 0, 0, 0, 8'h00, 0, 8'h00);
        step();
        rst_n = 1'b1;
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h50);
        step();
        chk_all("mid.after", 0, 0, 0, 8'h00, 0, 8'h00);
        step();
        chk_all("mid.after", 1, 0, 0, 8'h00, 0, 8'h00);
        // new one-byte session completes; the earlier bytes survived reset
        drive(1, 8'h60, 8'd1, 0, 8'h00, 8'h50);
        step();
        drive(0, 8'h00, 8'h00, 1, 8'h77, 8'h50);
        step();
        chk_all("mid.new", 0, 0, 1, 8'h77, 1, 8'h00);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h50);
        step();
        chk("mid.mem50", 0, 32'(bus.fetch_data), 32'hAB);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h51);
        step();
        chk("mid.mem51", 0, 32'(bus.fetch_data), 32'hCD);
        drive(0, 8'h00, 8'h00, 0, 8'h00, 8'h60);
        step();
        chk("mid.mem60", 0, 32'(bus.fetch_data), 32'h77);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
